// File: rtl/pip_mem_stage.sv
// pip_mem_stage: MEM stage of the 5-stage RISC-V pipeline.
// Turns EX/MEM load/store control into a req/ack bus transaction, aligns and
// extends load data, and stalls the pipeline while an access is outstanding.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN adds a BUSY timeout counter
// and the sticky mem_fault output.
//
// Bus handshake: bus_req is high for every BUSY cycle; bus_we, bus_addr,
// bus_wdata and bus_wstrb are held stable while bus_req is high (the EX/MEM
// register is frozen by mem_stall). The bus answers with a single-cycle
// bus_ack carrying bus_rdata. Any bus_ack seen outside BUSY is ignored.
module pip_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pip_en,
    input  logic [31:0] alu_out_p,
    input  logic [31:0] rs2_p,
    input  logic        DMread_p,
    input  logic        DMwriteEn_p,
    input  logic [2:0]  DM_ctrl_p,
    input  logic        rdEn_p,
    input  logic        rdmuxSel_p,
    output logic [31:0] wb_data,
    output logic        rdEn_wb,
    output logic        mem_stall,
    output logic        mem_excp,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
`ifdef MEM_ACCESS_TIMEOUT_EN
    output logic        mem_fault,
`endif
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] ld_data;
    logic [31:0] ld_ext;
    logic [3:0]  strb;
    logic [1:0]  a;
    logic        is_mem;
    logic        illegal;
    logic        misalign;
    logic        access;
    logic        timeout_hit;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign a      = alu_out_p[1:0];
    assign is_mem = DMread_p | DMwriteEn_p;

    // Classify funct3: reserved encodings are illegal, H/W need natural alignment
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        case (DM_ctrl_p)
            3'b000, 3'b100: misalign = 1'b0;
            3'b001, 3'b101: misalign = a[0];
            3'b010:         misalign = |a;
            default:        illegal  = 1'b1;
        endcase
    end

    assign mem_excp  = is_mem & (illegal | misalign);
    assign access    = is_mem & ~mem_excp;
    assign rdEn_wb   = rdEn_p & ~mem_excp;
    assign state_dbg = state;

    // Store lane strobes and replicated store data
    always_comb begin
        strb      = 4'b1111;
        bus_wdata = rs2_p;
        case (DM_ctrl_p[1:0])
            2'b00: begin
                strb      = 4'b0001 << a;
                bus_wdata = {4{rs2_p[7:0]}};
            end
            2'b01: begin
                strb      = a[1] ? 4'b1100 : 4'b0011;
                bus_wdata = {2{rs2_p[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                bus_wdata = rs2_p;
            end
        endcase
    end

    assign bus_we    = DMwriteEn_p;
    assign bus_addr  = {alu_out_p[31:2], 2'b00};
    assign bus_wstrb = DMwriteEn_p ? strb : 4'b0000;

    // Pick the addressed byte/half out of the read word and extend it
    always_comb begin
        sel_half = a[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (a)
            2'd0:    sel_byte = bus_rdata[7:0];
            2'd1:    sel_byte = bus_rdata[15:8];
            2'd2:    sel_byte = bus_rdata[23:16];
            default: sel_byte = bus_rdata[31:24];
        endcase
        case (DM_ctrl_p)
            3'b000:  ld_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  ld_ext = {24'b0, sel_byte};
            3'b001:  ld_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  ld_ext = {16'b0, sel_half};
            default: ld_ext = bus_rdata;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] busy_cnt;

    // Counts BUSY cycles of the current access; cleared when BUSY is entered
    always_ff @(posedge clk) begin
        if (rst)
            busy_cnt <= '0;
        else if (state != BUSY && state_n == BUSY)
            busy_cnt <= '0;
        else if (state == BUSY)
            busy_cnt <= busy_cnt + 1'b1;
    end

    assign timeout_hit = (busy_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Sticky abort flag, set when an access times out without an ack
    always_ff @(posedge clk) begin
        if (rst)
            mem_fault <= 1'b0;
        else if (state == BUSY && !bus_ack && timeout_hit)
            mem_fault <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and handshake outputs; DONE blocks reissue until pip_en
    always_comb begin
        state_n   = state;
        mem_stall = 1'b0;
        bus_req   = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = access;
                if (access)
                    state_n = BUSY;
            end
            BUSY: begin
                mem_stall = 1'b1;
                bus_req   = 1'b1;
                if (bus_ack || timeout_hit)
                    state_n = DONE;
            end
            DONE: begin
                if (pip_en)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Load data capture on ack; a timed-out access returns zero
    always_ff @(posedge clk) begin
        if (rst)
            ld_data <= 32'b0;
        else if (state == BUSY && bus_ack)
            ld_data <= ld_ext;
        else if (state == BUSY && timeout_hit)
            ld_data <= 32'b0;
    end

    assign wb_data = (rdmuxSel_p && state == DONE) ? ld_data : alu_out_p;

endmodule
